// File: rtl/sram_responder.sv
// SRAM-bus memory responder: byte-lane writes, registered reads,
// self-clearing init sweep after reset and a sticky out-of-range flag.
module sram_responder #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter logic [15:0] INIT_VALUE = 16'h0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [19:0] A,
    input  logic        CE,
    input  logic        OE,
    input  logic        WE,
    input  logic        UB,
    input  logic        LB,
    inout  wire  [15:0] I_O,
    output logic        init_busy,
    output logic        range_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    localparam logic [0:0] S_INIT  = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
    logic                  range_err_q, range_err_d;
    logic                  rd_q, rd_d;
    logic [15:0]           rdata_q, rdata_d;

    logic [15:0] mem [DEPTH];

    logic                  wr;
    logic                  rd;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;

    assign wr       = ~CE & ~WE;
    assign rd       = ~CE & ~OE & WE;
    assign in_range = (A >> DEPTH_LOG2) == 20'd0;
    assign idx      = A[DEPTH_LOG2-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        range_err_d = range_err_q;
        rd_d        = rd_q;
        rdata_d     = rdata_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + DEPTH_LOG2'(1);
            if (cnt_q == '1) begin
                state_d = S_READY;
            end
        end else begin
            rd_d = rd;
            if (rd) begin
                rdata_d = in_range ? mem[idx] : 16'h0000;
            end
            if ((wr | rd) & ~in_range) begin
                range_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            range_err_q <= 1'b0;
            rd_q        <= 1'b0;
            rdata_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            range_err_q <= range_err_d;
            rd_q        <= rd_d;
            rdata_q     <= rdata_d;
        end
    end

    // Array kept free of reset so it maps onto RAM; the sweep clears it.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (state_q == S_INIT) begin
                mem[cnt_q] <= INIT_VALUE;
            end else if (wr && in_range) begin
                if (!UB) mem[idx][15:8] <= I_O[15:8];
                if (!LB) mem[idx][7:0]  <= I_O[7:0];
            end
        end
    end

    assign I_O       = (rd_q && rd && !wr) ? rdata_q : 16'hzzzz;
    assign init_busy = (state_q == S_INIT);
    assign range_err = range_err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Vector-table bench for sram_responder with a read-data scoreboard;
// the bus has a pull-up so an undriven bus reads as 16'hFFFF.
module tb_sram_responder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [19:0] A = '0;
    logic        CE = 1'b1;
    logic        OE = 1'b1;
    logic        WE = 1'b1;
    logic        UB = 1'b1;
    logic        LB = 1'b1;
    tri1  [15:0] I_O;
    logic        init_busy;
    logic        range_err;

    logic        tb_drv = 1'b0;
    logic [15:0] tb_dout = '0;

    assign I_O = tb_drv ? tb_dout : 16'hzzzz;

    sram_responder dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .A         (A),
        .CE        (CE),
        .OE        (OE),
        .WE        (WE),
        .UB        (UB),
        .LB        (LB),
        .I_O       (I_O),
        .init_busy (init_busy),
        .range_err (range_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          ce, oe, we, ub, lb;
        logic [19:0] a;
        logic [15:0] wd;
        logic [15:0] exp;
        bit          err;
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];
    bit          prev_rd = 1'b0;

    function automatic vec_t mk(bit ce, bit oe, bit we, bit ub, bit lb,
                                logic [19:0] a, logic [15:0] wd,
                                logic [15:0] exp, bit err);
        vec_t v;
        v.ce = ce; v.oe = oe; v.we = we; v.ub = ub; v.lb = lb;
        v.a = a; v.wd = wd; v.exp = exp; v.err = err;
        return v;
    endfunction

    function automatic vec_t W(logic [19:0] a, logic [15:0] wd,
                               bit ub, bit lb, bit err);
        return mk(1'b0, 1'b1, 1'b0, ub, lb, a, wd, 16'h0, err);
    endfunction

    function automatic vec_t R(logic [19:0] a, logic [15:0] exp, bit err);
        return mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, a, 16'h0, exp, err);
    endfunction

    function automatic vec_t NOP(bit err);
        return mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 20'h0, 16'h0, 16'h0, err);
    endfunction

    function automatic vec_t CEH(bit err);
        return mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'h10, 16'h0, 16'h0, err);
    endfunction

    task automatic chk(input string nm, input int k,
                       input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, want %h", nm, k, act, exp);
        end
    endtask

    task automatic idle();
        CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b1; LB = 1'b1;
        tb_drv = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int k);
        bit rd, wr;
        logic [15:0] e;
        @(posedge Clk);
        #1;
        CE = v.ce; OE = v.oe; WE = v.we; UB = v.ub; LB = v.lb; A = v.a;
        wr = !v.ce && !v.we;
        rd = !v.ce && !v.oe && v.we;
        tb_drv  = wr;
        tb_dout = v.wd;
        @(negedge Clk);
        if (rd && prev_rd) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : ~I_O;
            chk("rdata", k, I_O, e);
        end else if (wr) begin
            chk("wr_bus", k, I_O, v.wd);
        end else begin
            chk("hiz", k, I_O, 16'hFFFF);
        end
        chk("range_err", k, {15'd0, range_err}, {15'd0, v.err});
        if (rd) exp_q.push_back(v.exp);
        else exp_q.delete();
        prev_rd = rd;
    endtask

    // Pulses Reset for one cycle (inputs left as they are), then times
    // the sweep; with poke set, a write to A=5 is driven during INIT.
    task automatic do_reset(input bit poke);
        int n;
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        chk("rst_hiz", 0, I_O, 16'hFFFF);
        chk("rst_busy", 0, {15'd0, init_busy}, 16'd1);
        chk("rst_err", 0, {15'd0, range_err}, 16'd0);
        prev_rd = 1'b0;
        exp_q.delete();
        idle();
        if (poke) begin
            CE = 1'b0; WE = 1'b0; UB = 1'b0; LB = 1'b0; A = 20'h5;
            tb_drv = 1'b1; tb_dout = 16'hBEEF;
        end
        n = 1;
        while (n < 2000) begin
            @(negedge Clk);
            if (!init_busy) break;
            n++;
            if (n == 200) idle();
        end
        chk("init_len", 0, 16'(n), 16'd256);
    endtask

    initial begin
        vec_t t1[$];
        vec_t t2[$];

        // init contents and ignored INIT-time write
        t1.push_back(R(20'h0, 16'h0, 0));
        t1.push_back(R(20'h0, 16'h0, 0));
        t1.push_back(R(20'h7F, 16'h0, 0));
        t1.push_back(R(20'h7F, 16'h0, 0));
        t1.push_back(R(20'hFF, 16'h0, 0));
        t1.push_back(R(20'hFF, 16'h0, 0));
        t1.push_back(R(20'h5, 16'h0, 0));
        t1.push_back(R(20'h5, 16'h0, 0));
        t1.push_back(NOP(0));
        // byte lanes, read hold, turnaround, CE high
        t1.push_back(W(20'h10, 16'h1234, 0, 0, 0));
        t1.push_back(W(20'h10, 16'hAB00, 0, 1, 0));
        t1.push_back(R(20'h10, 16'hAB34, 0));
        t1.push_back(R(20'h10, 16'hAB34, 0));
        t1.push_back(R(20'h10, 16'hAB34, 0));
        t1.push_back(W(20'h10, 16'h5A5A, 1, 1, 0));
        t1.push_back(R(20'h10, 16'hAB34, 0));
        t1.push_back(R(20'h10, 16'hAB34, 0));
        t1.push_back(CEH(0));
        // out of range
        t1.push_back(W(20'h00100, 16'h5555, 0, 0, 0));
        t1.push_back(R(20'h0, 16'h0, 1));
        t1.push_back(R(20'h0, 16'h0, 1));
        t1.push_back(R(20'hFFFFF, 16'h0, 1));
        t1.push_back(R(20'hFFFFF, 16'h0, 1));
        t1.push_back(NOP(1));
        // back-to-back write/read and streaming reads
        t1.push_back(W(20'h20, 16'hC0DE, 0, 0, 1));
        t1.push_back(R(20'h20, 16'hC0DE, 1));
        t1.push_back(R(20'h20, 16'hC0DE, 1));
        t1.push_back(W(20'h1, 16'h0001, 0, 0, 1));
        t1.push_back(W(20'h2, 16'h0002, 0, 0, 1));
        t1.push_back(W(20'h3, 16'h0003, 0, 0, 1));
        t1.push_back(R(20'h1, 16'h0001, 1));
        t1.push_back(R(20'h2, 16'h0002, 1));
        t1.push_back(R(20'h3, 16'h0003, 1));
        t1.push_back(R(20'h3, 16'h0003, 1));
        t1.push_back(W(20'h40, 16'hFFFF, 0, 0, 1));
        t1.push_back(R(20'h10, 16'hAB34, 1));
        t1.push_back(R(20'h10, 16'hAB34, 1));

        t2.push_back(R(20'h40, 16'h0, 0));
        t2.push_back(R(20'h40, 16'h0, 0));
        t2.push_back(R(20'h10, 16'h0, 0));
        t2.push_back(R(20'h10, 16'h0, 0));
        t2.push_back(R(20'h20, 16'h0, 0));
        t2.push_back(R(20'h20, 16'h0, 0));

        do_reset(1'b1);
        foreach (t1[i]) apply(t1[i], i);
        do_reset(1'b0);
        foreach (t2[i]) apply(t2[i], 100 + i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
